// File: rtl/dsp_post_adder_accum.sv
// Post-adder/accumulator stage of a DSP48A1-style slice: OPMODE-selected X/Z operands,
// 48-bit add/subtract with carry-in, P and CARRYOUT registers, P cascade and carry outputs.
module dsp_post_adder_accum #(
    parameter int    OPMODEREG   = 1,
    parameter int    CARRYINREG  = 1,
    parameter int    PREG        = 1,
    parameter int    CARRYOUTREG = 1,
    parameter string CARRYINSEL  = "OPMODE5"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce_opmode,
    input  logic        ce_carryin,
    input  logic        ce_p,
    input  logic        ce_carryout,
    input  logic [7:0]  opmode,
    input  logic        carryin,
    input  logic [35:0] m,
    input  logic [47:0] dab,
    input  logic [47:0] c,
    input  logic [47:0] pcin,
    output logic [47:0] p,
    output logic [47:0] pcout,
    output logic        carryout,
    output logic        carryoutf
);

    localparam bit CIN_FROM_PORT = (CARRYINSEL == "CARRYIN");
    localparam bit OPM_BYPASS    = (OPMODEREG == 0);
    localparam bit CIN_BYPASS    = (CARRYINREG == 0);
    localparam bit P_BYPASS      = (PREG == 0);
    localparam bit CO_BYPASS     = (CARRYOUTREG == 0);

    logic [7:0]  opm_q;
    logic [7:0]  opm;
    logic        cin_src;
    logic        cin_q;
    logic        cin;
    logic [47:0] x_mux;
    logic [47:0] z_mux;
    logic [48:0] addend;
    logic [48:0] result;
    logic [47:0] p_d;
    logic [47:0] p_q;
    logic        p_load;
    logic        co_d;
    logic        co_q;

    assign cin_src = CIN_FROM_PORT ? carryin : opmode[5];

    // Carry-in register samples at the same edge as the OPMODE register.
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opm_q <= '0;
            cin_q <= 1'b0;
        end else begin
            if (ce_opmode) begin
                opm_q <= opmode;
            end
            if (ce_carryin) begin
                cin_q <= cin_src;
            end
        end
    end

    assign opm = OPM_BYPASS ? opmode  : opm_q;
    assign cin = CIN_BYPASS ? cin_src : cin_q;

    // NOTE: every case path has a default so the muxes stay combinational, never latches.
    always_comb begin
        x_mux = '0;
        case (opm[1:0])
            2'b01:   x_mux = {12'b0, m};
            2'b10:   x_mux = p_q;
            2'b11:   x_mux = dab;
            default: x_mux = '0;
        endcase
    end

    always_comb begin
        z_mux = '0;
        case (opm[3:2])
            2'b01:   z_mux = pcin;
            2'b10:   z_mux = p_q;
            2'b11:   z_mux = c;
            default: z_mux = '0;
        endcase
    end

    // 49-bit unsigned arithmetic; bit 48 is carry on add and borrow on subtract.
    assign addend = {1'b0, x_mux} + {48'b0, cin};
    assign result = opm[7] ? ({1'b0, z_mux} - addend) : ({1'b0, z_mux} + addend);
    assign p_d    = result[47:0];
    assign co_d   = result[48];

    // With P bypassed the register still tracks the result so feedback never loops combinationally.
    assign p_load = P_BYPASS || ce_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q  <= '0;
            co_q <= 1'b0;
        end else begin
            if (p_load) begin
                p_q <= p_d;
            end
            if (ce_carryout) begin
                co_q <= co_d;
            end
        end
    end

    assign p         = P_BYPASS  ? p_d  : p_q;
    assign pcout     = p;
    assign carryout  = CO_BYPASS ? co_d : co_q;
    assign carryoutf = carryout;

    logic unused_bits;
    assign unused_bits = ^{opm[6:4], opmode[6], opmode[4], carryin};

endmodule

// File: tb/tb_dsp_post_adder_accum.sv
// Self-checking bench for dsp_post_adder_accum: three parameterisations driven with shared
// stimulus, compared to a behavioural model plus directed constant expectations.
module tb_dsp_post_adder_accum;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ce_opmode, ce_carryin, ce_p, ce_carryout;
    logic [7:0]  opmode;
    logic        carryin;
    logic [35:0] m;
    logic [47:0] dab, c, pcin;

    logic [47:0] p_reg, pcout_reg, p_byp, pcout_byp, p_comb, pcout_comb;
    logic        co_reg, cof_reg, co_byp, cof_byp, co_comb, cof_comb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // All registers enabled, carry-in from opmode[5].
    dsp_post_adder_accum u_reg (
        .clk(clk), .rst_n(rst_n), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin),
        .ce_p(ce_p), .ce_carryout(ce_carryout), .opmode(opmode), .carryin(carryin),
        .m(m), .dab(dab), .c(c), .pcin(pcin),
        .p(p_reg), .pcout(pcout_reg), .carryout(co_reg), .carryoutf(cof_reg)
    );

    // OPMODE and carry-in combinational, carry-in from the port.
    dsp_post_adder_accum #(.OPMODEREG(0), .CARRYINREG(0), .CARRYINSEL("CARRYIN")) u_byp (
        .clk(clk), .rst_n(rst_n), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin),
        .ce_p(ce_p), .ce_carryout(ce_carryout), .opmode(opmode), .carryin(carryin),
        .m(m), .dab(dab), .c(c), .pcin(pcin),
        .p(p_byp), .pcout(pcout_byp), .carryout(co_byp), .carryoutf(cof_byp)
    );

    // P and CARRYOUT combinational.
    dsp_post_adder_accum #(.PREG(0), .CARRYOUTREG(0)) u_comb (
        .clk(clk), .rst_n(rst_n), .ce_opmode(ce_opmode), .ce_carryin(ce_carryin),
        .ce_p(ce_p), .ce_carryout(ce_carryout), .opmode(opmode), .carryin(carryin),
        .m(m), .dab(dab), .c(c), .pcin(pcin),
        .p(p_comb), .pcout(pcout_comb), .carryout(co_comb), .carryoutf(cof_comb)
    );

    // Reference arithmetic: pick operands by the select fields, do it in 64 bits, keep 49.
    function automatic logic [48:0] ref_result(input logic [7:0] opm, input logic cin,
                                               input logic [47:0] pfb, input logic [35:0] mm,
                                               input logic [47:0] dd, input logic [47:0] cc,
                                               input logic [47:0] pc);
        longint unsigned x, z, r;
        case (opm[1:0])
            2'd0:    x = 0;
            2'd1:    x = longint'(mm);
            2'd2:    x = longint'(pfb);
            default: x = longint'(dd);
        endcase
        case (opm[3:2])
            2'd0:    z = 0;
            2'd1:    z = longint'(pc);
            2'd2:    z = longint'(pfb);
            default: z = longint'(cc);
        endcase
        if (opm[7]) r = z - (x + longint'(cin));
        else        r = z + x + longint'(cin);
        return r[48:0];
    endfunction

    logic [47:0] reg_p, byp_p, comb_p;
    logic        reg_co, byp_co;
    logic [7:0]  reg_opm, comb_opm;
    logic        reg_cin, comb_cin;
    logic [48:0] r_reg, r_byp, r_comb;

    assign r_reg  = ref_result(reg_opm,  reg_cin,  reg_p,  m, dab, c, pcin);
    assign r_byp  = ref_result(opmode,   carryin,  byp_p,  m, dab, c, pcin);
    assign r_comb = ref_result(comb_opm, comb_cin, comb_p, m, dab, c, pcin);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_p <= '0; byp_p <= '0; comb_p <= '0;
            reg_co <= 1'b0; byp_co <= 1'b0;
            reg_opm <= '0; comb_opm <= '0;
            reg_cin <= 1'b0; comb_cin <= 1'b0;
        end else begin
            if (ce_p)        reg_p   <= r_reg[47:0];
            if (ce_carryout) reg_co  <= r_reg[48];
            if (ce_opmode)   reg_opm <= opmode;
            if (ce_carryin)  reg_cin <= opmode[5];
            if (ce_p)        byp_p   <= r_byp[47:0];
            if (ce_carryout) byp_co  <= r_byp[48];
            comb_p <= r_comb[47:0];
            if (ce_opmode)   comb_opm <= opmode;
            if (ce_carryin)  comb_cin <= opmode[5];
        end
    end

    task automatic check(input string tag, input logic [48:0] obs, input logic [48:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
            $error("%s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, " p_reg"},      49'(p_reg),      49'(reg_p));
        check({tag, " pcout_reg"},  49'(pcout_reg),  49'(reg_p));
        check({tag, " co_reg"},     49'(co_reg),     49'(reg_co));
        check({tag, " cof_reg"},    49'(cof_reg),    49'(reg_co));
        check({tag, " p_byp"},      49'(p_byp),      49'(byp_p));
        check({tag, " pcout_byp"},  49'(pcout_byp),  49'(byp_p));
        check({tag, " co_byp"},     49'(co_byp),     49'(byp_co));
        check({tag, " cof_byp"},    49'(cof_byp),    49'(byp_co));
        check({tag, " p_comb"},     49'(p_comb),     49'(r_comb[47:0]));
        check({tag, " pcout_comb"}, 49'(pcout_comb), 49'(r_comb[47:0]));
        check({tag, " co_comb"},    49'(co_comb),    49'(r_comb[48]));
        check({tag, " cof_comb"},   49'(cof_comb),   49'(r_comb[48]));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        // Reset held with every input nonzero.
        rst_n = 1'b0;
        ce_opmode = 1'b1; ce_carryin = 1'b1; ce_p = 1'b1; ce_carryout = 1'b1;
        opmode = 8'hFF; carryin = 1'b1;
        m = 36'hA_5A5A_5A5A; dab = 48'h1234_5678_9ABC; c = 48'hFEDC_BA98_7654; pcin = 48'h0F0F_0F0F_0F0F;
        step("reset");
        step("reset");
        check("reset p",   49'(p_reg),   49'd0);
        check("reset co",  49'(co_reg),  49'd0);
        check("reset cof", 49'(cof_reg), 49'd0);

        // MAC: X = M, Z = P. First edge applies the cleared OPMODE register.
        rst_n = 1'b1; opmode = 8'b0000_1001; m = 36'd5; carryin = 1'b0;
        step("mac prime");
        check("mac prime p", 49'(p_reg), 49'd0);
        for (int i = 1; i <= 4; i++) begin
            step("mac");
            check("mac p", 49'(p_reg), 49'(5 * i));
        end

        // P enable low holds the accumulator.
        ce_p = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("ce_p hold");
            check("ce_p hold p", 49'(p_reg), 49'd20);
        end
        ce_p = 1'b1;
        step("ce_p resume");
        check("ce_p resume p", 49'(p_reg), 49'd25);
        step("ce_p resume");
        check("ce_p resume p", 49'(p_reg), 49'd30);

        // OPMODE enable low keeps the old opmode applying.
        ce_opmode = 1'b0; opmode = 8'h00;
        step("ce_opmode hold");
        check("ce_opmode hold p", 49'(p_reg), 49'd35);
        step("ce_opmode hold");
        check("ce_opmode hold p", 49'(p_reg), 49'd40);
        ce_opmode = 1'b1; opmode = 8'b0000_1001;

        // Asynchronous reset between edges mid-accumulation.
        m = 36'd7;
        #2 rst_n = 1'b0;
        #1;
        check("async rst p",     49'(p_reg),     49'd0);
        check("async rst pcout", 49'(pcout_reg), 49'd0);
        check("async rst co",    49'(co_reg),    49'd0);
        check_all("async rst");
        #1 rst_n = 1'b1; m = 36'd5;
        step("post rst");
        check("post rst p", 49'(p_reg), 49'd0);
        step("post rst");
        check("post rst p", 49'(p_reg), 49'd5);
        step("post rst");
        check("post rst p", 49'(p_reg), 49'd10);

        // Subtract: Z = C, X = M.
        opmode = 8'b1000_1101; c = 48'd10; m = 36'd3;
        step("sub load");
        step("sub");
        check("sub p",  49'(p_reg),  49'd7);
        check("sub co", 49'(co_reg), 49'd0);
        c = 48'd3; m = 36'd10;
        step("sub borrow");
        check("sub borrow p",   49'(p_reg),   49'h0_FFFF_FFFF_FFF9);
        check("sub borrow co",  49'(co_reg),  49'd1);
        check("sub borrow cof", 49'(cof_reg), 49'd1);

        // Carry wrap: X = DAB all ones, carry-in from opmode[5].
        opmode = 8'b0010_0011; dab = 48'hFFFF_FFFF_FFFF;
        step("wrap load");
        step("wrap");
        check("wrap p",   49'(p_reg),   49'd0);
        check("wrap co",  49'(co_reg),  49'd1);
        check("wrap cof", 49'(cof_reg), 49'd1);
        opmode = 8'b0000_0011;
        step("wrap clear load");
        step("wrap clear");
        check("wrap clear p",  49'(p_reg),  49'h0_FFFF_FFFF_FFFF);
        check("wrap clear co", 49'(co_reg), 49'd0);

        // Bypassed OPMODE/carry-in with cascade input.
        opmode = 8'b0000_0100; carryin = 1'b1; pcin = 48'd100;
        step("bypass");
        check("bypass p",     49'(p_byp),     49'd101);
        check("bypass pcout", 49'(pcout_byp), 49'd101);
        check("bypass co",    49'(co_byp),    49'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 80; i++) begin
            opmode      = 8'($urandom());
            carryin     = 1'($urandom());
            m           = 36'({$urandom(), $urandom()});
            dab         = 48'({$urandom(), $urandom()});
            c           = 48'({$urandom(), $urandom()});
            pcin        = 48'({$urandom(), $urandom()});
            ce_opmode   = ($urandom_range(0, 3) != 0);
            ce_carryin  = ($urandom_range(0, 3) != 0);
            ce_p        = ($urandom_range(0, 3) != 0);
            ce_carryout = ($urandom_range(0, 3) != 0);
            step("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
